shared_mem_arbiter: RTL and testbench

- Parametrised, multi-channel successor to the single-port instruction/data memory tops.
- One word-addressed, byte-maskable memory is shared by NUM_CH requesters, for example core instruction fetch and core load/store.
- Each channel uses the request/we_re/mask/valid handshake the core already speaks.
- Round-robin arbitration and a configurable wait-state count model slower memory.

---
 rtl/shared_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: one byte-maskable word memory shared by NUM_CH
// requesters. Round-robin arbitration, WAIT_STATES extra access cycles,
// one transaction in flight, single-cycle valid pulse per completion.
module shared_mem_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_CH-1:0]                           request,
  input  logic [NUM_CH-1:0]                           we_re,
  input  logic [NUM_CH*ADDR_W-1:0]                    address,
  input  logic [NUM_CH*DATA_W-1:0]                    data_in,
  input  logic [NUM_CH*(DATA_W/8)-1:0]                mask,
  output logic [NUM_CH-1:0]                           valid,
  output logic [NUM_CH*DATA_W-1:0]                    data_out,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] grant,
  output logic                                        busy
);

  localparam int MASK_W  = DATA_W / 8;
  localparam int GRANT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DEPTH   = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_n_s;
  logic [GRANT_W-1:0]   grant_r;
  logic [GRANT_W-1:0]   rr_ptr_r;
  logic [GRANT_W-1:0]   win_idx_s;
  logic [3:0]           cnt_r;
  logic                 lat_we_r;
  logic [ADDR_W-1:0]    lat_addr_r;
  logic [DATA_W-1:0]    lat_data_r;
  logic [MASK_W-1:0]    lat_mask_r;
  logic [NUM_CH-1:0]    valid_r;
  logic [NUM_CH-1:0]    valid_n_s;
  logic [NUM_CH*DATA_W-1:0] data_out_r;
  logic                 busy_r;
  logic                 busy_n_s;
  logic                 accept_s;
  logic                 commit_s;
  logic                 wr_commit_s;
  logic                 rd_commit_s;
  logic [DATA_W-1:0]    mem_r [DEPTH];

  // Expand a per-byte enable into a per-bit mask.
  function automatic logic [DATA_W-1:0] mask_expand(input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] res;
    res = '0;
    for (int b = 0; b < MASK_W; b++) begin
      res[b*8 +: 8] = {8{m[b]}};
    end
    return res;
  endfunction

  // Round-robin pick: first requester at or above the pointer, wrapping.
  always_comb begin
    logic found;
    int   idx;
    found     = 1'b0;
    win_idx_s = '0;
    idx       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_ptr_r) + i) % NUM_CH;
      if (!found && request[idx]) begin
        found     = 1'b1;
        win_idx_s = GRANT_W'(idx);
      end else begin
        found = found;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (|request) state_n_s = ACCESS;
        else          state_n_s = IDLE;
      end
      ACCESS: begin
        if (cnt_r == 4'd0) state_n_s = RESP;
        else               state_n_s = ACCESS;
      end
      RESP:    state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
  end

  // FSM output decode: accept/commit strobes and next values of the output registers.
  always_comb begin
    accept_s    = (state_r == IDLE) && (|request);
    commit_s    = (state_r == ACCESS) && (cnt_r == 4'd0);
    wr_commit_s = commit_s && lat_we_r;
    rd_commit_s = commit_s && !lat_we_r;
    busy_n_s    = (state_n_s != IDLE);
    valid_n_s   = '0;
    if (commit_s) begin
      valid_n_s[grant_r] = 1'b1;
    end else begin
      valid_n_s = '0;
    end
  end

  // Transaction latch, wait counter, rr pointer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_r    <= '0;
      rr_ptr_r   <= '0;
      cnt_r      <= 4'd0;
      lat_we_r   <= 1'b0;
      lat_addr_r <= '0;
      lat_data_r <= '0;
      lat_mask_r <= '0;
      valid_r    <= '0;
      busy_r     <= 1'b0;
      data_out_r <= '0;
    end else begin
      valid_r <= valid_n_s;
      busy_r  <= busy_n_s;
      if (accept_s) begin
        grant_r    <= win_idx_s;
        lat_we_r   <= we_re[win_idx_s];
        lat_addr_r <= address[int'(win_idx_s)*ADDR_W +: ADDR_W];
        lat_data_r <= data_in[int'(win_idx_s)*DATA_W +: DATA_W];
        lat_mask_r <= mask[int'(win_idx_s)*MASK_W +: MASK_W];
        cnt_r      <= 4'(WAIT_STATES);
      end else if ((state_r == ACCESS) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (rd_commit_s) begin
        data_out_r[int'(grant_r)*DATA_W +: DATA_W] <= mem_r[lat_addr_r] & mask_expand(lat_mask_r);
      end
      if (state_r == RESP) begin
        if (int'(grant_r) == NUM_CH - 1) rr_ptr_r <= '0;
        else                             rr_ptr_r <= grant_r + GRANT_W'(1);
      end
    end
  end

  // Memory array: byte-masked write on commit; contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < MASK_W; b++) begin
      if (wr_commit_s && lat_mask_r[b]) begin
        mem_r[lat_addr_r][b*8 +: 8] <= lat_data_r[b*8 +: 8];
      end
    end
  end

  assign valid    = valid_r;
  assign data_out = data_out_r;
  assign grant    = grant_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Scoreboard bench for shared_mem_arbiter: dut0 has no wait states, dut3 has
// three. Stimulus pushes expected completions; a negedge monitor pops them.
module tb_shared_mem_arbiter;

  typedef struct {
    int          ch;
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } sb_t;

  logic        clk = 1'b0;
  logic        rstn [2];
  logic [1:0]  req  [2];
  logic [1:0]  we   [2];
  logic [15:0] addr [2];
  logic [63:0] din  [2];
  logic [7:0]  msk  [2];
  logic [1:0]  vld  [2];
  logic [63:0] dout [2];
  logic        gnt  [2];
  logic        bsy  [2];

  logic [31:0] shadow [2][2];
  sb_t         q0[$];
  sb_t         q1[$];
  int          cyc   = 0;
  int          total = 0;
  int          pass  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shared_mem_arbiter #(.NUM_CH(2), .ADDR_W(8), .DATA_W(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rstn[0]), .request(req[0]), .we_re(we[0]), .address(addr[0]),
    .data_in(din[0]), .mask(msk[0]), .valid(vld[0]), .data_out(dout[0]),
    .grant(gnt[0]), .busy(bsy[0]));

  shared_mem_arbiter #(.NUM_CH(2), .ADDR_W(8), .DATA_W(32), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rstn[1]), .request(req[1]), .we_re(we[1]), .address(addr[1]),
    .data_in(din[1]), .mask(msk[1]), .valid(vld[1]), .data_out(dout[1]),
    .grant(gnt[1]), .busy(bsy[1]));

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic set_fields(input int d, input int ch, input logic w, input logic [7:0] a,
                            input logic [31:0] data, input logic [3:0] m);
    we[d][ch]          = w;
    addr[d][ch*8 +: 8] = a;
    din[d][ch*32 +: 32] = data;
    msk[d][ch*4 +: 4]  = m;
  endtask

  task automatic push(input int d, input int ch, input bit rd, input logic [31:0] data, input int c);
    sb_t e;
    e.ch = ch; e.rd = rd; e.data = data; e.cyc = c;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic wait_valid(input int d, input int ch);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (vld[d][ch]) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      $display("FAIL timeout_valid: dut%0d ch%0d got no valid, expected one within 40 cycles", d, ch);
    end
  endtask

  // One transaction from an idle arbiter; optional address change during ACCESS
  // and optional busy-length check.
  task automatic txn(input int d, input int ch, input logic w, input logic [7:0] a,
                     input logic [31:0] data, input logic [3:0] m, input logic [31:0] exp_rd,
                     input bit alt_en, input logic [7:0] alt_a, input int busy_exp);
    int bcnt;
    bit seen;
    @(negedge clk);
    set_fields(d, ch, w, a, data, m);
    req[d][ch] = 1'b1;
    push(d, ch, !w, exp_rd, cyc + 2 + ws(d));
    bcnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (alt_en && k == 0) addr[d][ch*8 +: 8] = alt_a;
      if (bsy[d]) bcnt++;
      if (vld[d][ch]) seen = 1'b1;
    end
    req[d][ch] = 1'b0;
    if (!seen) begin
      total++;
      $display("FAIL timeout_txn: dut%0d ch%0d got no valid, expected one within 40 cycles", d, ch);
    end
    if (busy_exp != 0) begin
      @(negedge clk);
      chk("busy_cycles", bcnt, busy_exp);
      chk("busy_low_after", 32'(bsy[d]), 32'd0);
    end
  endtask

  // Monitor: every valid pulse must match the next scoreboard entry.
  always @(negedge clk) begin : monitor
    sb_t        e;
    logic [1:0] oh;
    for (int d = 0; d < 2; d++) begin
      if (!rstn[d]) begin
        shadow[d][0] = 32'h0;
        shadow[d][1] = 32'h0;
      end
      if (vld[d] != 2'b00) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          total++;
          $display("FAIL unexpected_valid: dut%0d valid=%b, expected no pulse", d, vld[d]);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          oh = 2'b01 << e.ch;
          chk("valid_onehot", 32'(vld[d]), 32'(oh));
          chk("grant", 32'(gnt[d]), 32'(e.ch));
          chk("valid_cycle", cyc, e.cyc);
          if (e.rd) shadow[d][e.ch] = e.data;
          chk("dout_ch0", dout[d][31:0], shadow[d][0]);
          chk("dout_ch1", dout[d][63:32], shadow[d][1]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int c;
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; req[d] = 2'b00; we[d] = 2'b00;
      addr[d] = 16'h0; din[d] = 64'h0; msk[d] = 8'h0;
      shadow[d][0] = 32'h0; shadow[d][1] = 32'h0;
    end
    // Reset with both channels requesting; they keep requesting afterwards.
    set_fields(0, 0, 1'b1, 8'h40, 32'h1111_1111, 4'hF);
    set_fields(0, 1, 1'b1, 8'h41, 32'h2222_2222, 4'hF);
    req[0] = 2'b11;
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", 32'(vld[0]), 32'd0);
      chk("rst_busy", 32'(bsy[0]), 32'd0);
      chk("rst_dout", dout[0][31:0] | dout[0][63:32], 32'd0);
      chk("rst_grant", 32'(gnt[0]), 32'd0);
    end
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    c = cyc;
    // Round robin: ch0, ch1, ch0, ch1 every three cycles.
    push(0, 0, 1'b0, 32'h0, c + 2);
    push(0, 1, 1'b0, 32'h0, c + 5);
    push(0, 0, 1'b1, 32'h1111_1111, c + 8);
    push(0, 1, 1'b1, 32'h2222_2222, c + 11);
    wait_valid(0, 0);
    set_fields(0, 0, 1'b0, 8'h40, 32'h0, 4'hF);
    wait_valid(0, 1);
    set_fields(0, 1, 1'b0, 8'h41, 32'h0, 4'hF);
    wait_valid(0, 0);
    req[0][0] = 1'b0;
    wait_valid(0, 1);
    req[0][1] = 1'b0;

    // Single write/read and byte masks, no wait states.
    txn(0, 0, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 8'h0, 0);
    txn(0, 0, 1'b0, 8'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 8'h0, 0);
    txn(0, 1, 1'b1, 8'h03, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0, 8'h0, 0);
    txn(0, 0, 1'b1, 8'h03, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 8'h0, 0);
    txn(0, 1, 1'b0, 8'h03, 32'h0, 4'hF, 32'hAA22_CC44, 1'b0, 8'h0, 0);
    txn(0, 0, 1'b0, 8'h03, 32'h0, 4'b0011, 32'h0000_CC44, 1'b0, 8'h0, 2);

    // Three wait states: latency, address change during ACCESS, busy length.
    txn(1, 0, 1'b1, 8'h30, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 8'h0, 0);
    txn(1, 1, 1'b1, 8'h31, 32'h9ABC_DEF0, 4'hF, 32'h0, 1'b0, 8'h0, 0);
    txn(1, 0, 1'b0, 8'h30, 32'h0, 4'hF, 32'h1234_5678, 1'b1, 8'h31, 5);
    txn(1, 1, 1'b1, 8'h20, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0, 8'h0, 0);

    // Reset two cycles into a write: nothing commits, no valid.
    @(negedge clk);
    set_fields(1, 1, 1'b1, 8'h20, 32'hFFFF_FFFF, 4'hF);
    req[1][1] = 1'b1;
    repeat (3) @(negedge clk);
    rstn[1] = 1'b0;
    req[1][1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_valid", 32'(vld[1]), 32'd0);
      chk("midrst_busy", 32'(bsy[1]), 32'd0);
    end
    rstn[1] = 1'b1;
    // Mask-zero write completes without changing memory.
    txn(1, 0, 1'b1, 8'h20, 32'h0000_0000, 4'h0, 32'h0, 1'b0, 8'h0, 0);
    txn(1, 0, 1'b0, 8'h20, 32'h0, 4'hF, 32'hA5A5_A5A5, 1'b0, 8'h0, 0);

    repeat (6) @(negedge clk);
    chk("sb_drain_dut0", q0.size(), 32'd0);
    chk("sb_drain_dut3", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
